// File: rtl/spike_readout_arbiter.sv
// Round-robin readout of per-neuron spike counts, with a periodic 128-entry clear sweep on window expiry.
// Read data appears 2 cycles after the grant; requesters wait (level req held) while a read or clear is busy.

module spike_readout_arbiter #(
    parameter int N_REQ    = 4,
    parameter int N_NEURON = 128
) (
    input  logic                              clk,
    input  logic                              reset_bar,
    input  logic [31:0]                       window_len,
    input  logic [N_REQ-1:0]                  req,
    input  logic [N_REQ*$clog2(N_NEURON)-1:0] req_idx,
    output logic [N_REQ-1:0]                  grant,
    output logic                              mem_rd_en,
    output logic                              mem_clr_en,
    output logic [$clog2(N_NEURON)-1:0]       mem_addr,
    input  logic [31:0]                       mem_rdata,
    output logic                              rd_valid,
    output logic [31:0]                       rd_data,
    output logic [$clog2(N_REQ)-1:0]          rd_tag,
    output logic                              window_tick,
    output logic                              clearing,
    output logic                              window_overrun
);

    localparam int AW = $clog2(N_NEURON);
    localparam int TW = $clog2(N_REQ);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_CLEAR
    } state_t;

    state_t             r_state;
    logic [TW-1:0]      r_ptr;
    logic [31:0]        r_wcnt;
    logic [31:0]        r_wlen;
    logic               r_clear_pending;
    logic [N_REQ-1:0]   r_grant;
    logic               r_mem_rd_en;
    logic               r_mem_clr_en;
    logic [AW-1:0]      r_mem_addr;
    logic               r_rd_cap;
    logic [TW-1:0]      r_rd_tag_pend;
    logic               r_rd_valid;
    logic [31:0]        r_rd_data;
    logic [TW-1:0]      r_rd_tag;
    logic               r_window_tick;
    logic               r_clearing;
    logic               r_window_overrun;

    logic               w_any;
    logic [TW-1:0]      w_sel;
    logic [TW-1:0]      w_scan;
    logic [N_REQ-1:0]   w_sel_oh;
    logic [AW-1:0]      w_sel_idx;
    logic [31:0]        w_len;
    logic               w_expire;

    // Scan downward so the requester closest to the pointer is the last (winning) match.
    always_comb begin
        w_any  = 1'b0;
        w_sel  = '0;
        w_scan = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_scan = r_ptr + TW'(k);
            if (req[w_scan]) begin
                w_any = 1'b1;
                w_sel = w_scan;
            end
        end
    end

    assign w_sel_oh  = {{(N_REQ-1){1'b0}}, 1'b1} << w_sel;
    assign w_sel_idx = req_idx[int'(w_sel)*AW +: AW];

    // A zero latched length means "not yet latched": follow the live input until a window starts.
    assign w_len    = (r_wlen == 32'd0) ? window_len : r_wlen;
    assign w_expire = (w_len != 32'd0) && (r_wcnt == w_len - 32'd1);

    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            r_state          <= S_IDLE;
            r_ptr            <= '0;
            r_wcnt           <= '0;
            r_wlen           <= '0;
            r_clear_pending  <= 1'b0;
            r_grant          <= '0;
            r_mem_rd_en      <= 1'b0;
            r_mem_clr_en     <= 1'b0;
            r_mem_addr       <= '0;
            r_rd_cap         <= 1'b0;
            r_rd_tag_pend    <= '0;
            r_rd_valid       <= 1'b0;
            r_rd_data        <= '0;
            r_rd_tag         <= '0;
            r_window_tick    <= 1'b0;
            r_clearing       <= 1'b0;
            r_window_overrun <= 1'b0;
        end else begin
            r_grant       <= '0;
            r_mem_rd_en   <= 1'b0;
            r_window_tick <= 1'b0;
            r_rd_cap      <= 1'b0;
            r_rd_valid    <= r_rd_cap;
            if (r_rd_cap) begin
                r_rd_data <= mem_rdata;
                r_rd_tag  <= r_rd_tag_pend;
            end

            if (w_expire || r_wlen == 32'd0) begin
                r_wlen <= window_len;
            end
            if (w_expire || w_len == 32'd0) begin
                r_wcnt <= '0;
            end else begin
                r_wcnt <= r_wcnt + 32'd1;
            end

            case (r_state)
                S_IDLE: begin
                    if (r_clear_pending) begin
                        r_state         <= S_CLEAR;
                        r_clear_pending <= 1'b0;
                        r_mem_clr_en    <= 1'b1;
                        r_mem_addr      <= '0;
                        r_clearing      <= 1'b1;
                        r_window_tick   <= 1'b1;
                    end else if (w_any) begin
                        r_state       <= S_READ;
                        r_grant       <= w_sel_oh;
                        r_mem_rd_en   <= 1'b1;
                        r_mem_addr    <= w_sel_idx;
                        r_rd_tag_pend <= w_sel;
                        r_ptr         <= w_sel + TW'(1);
                    end
                end
                S_READ: begin
                    r_state  <= S_IDLE;
                    r_rd_cap <= 1'b1;
                end
                S_CLEAR: begin
                    if (r_mem_addr == AW'(N_NEURON - 1)) begin
                        r_state      <= S_IDLE;
                        r_mem_clr_en <= 1'b0;
                        r_clearing   <= 1'b0;
                    end else begin
                        r_mem_addr <= r_mem_addr + AW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // An expiry that finds a clear already owed or running is dropped and flagged.
            if (w_expire) begin
                if (r_clear_pending || r_clearing) begin
                    r_window_overrun <= 1'b1;
                end else begin
                    r_clear_pending <= 1'b1;
                end
            end
        end
    end

    assign grant          = r_grant;
    assign mem_rd_en      = r_mem_rd_en;
    assign mem_clr_en     = r_mem_clr_en;
    assign mem_addr       = r_mem_addr;
    assign rd_valid       = r_rd_valid;
    assign rd_data        = r_rd_data;
    assign rd_tag         = r_rd_tag;
    assign window_tick    = r_window_tick;
    assign clearing       = r_clearing;
    assign window_overrun = r_window_overrun;

endmodule

// File: tb/tb_spike_readout_arbiter.sv
// Directed and randomized bench for spike_readout_arbiter; expectations come from a cycle-number
// model (window expiry times, clear intervals, grant timestamps) rather than from state machines.

module tb_spike_readout_arbiter;

    logic        clk = 1'b0;
    logic        reset_bar = 1'b0;
    logic [31:0] window_len = '0;
    logic [3:0]  req = '0;
    logic [27:0] req_idx = '0;
    logic [3:0]  grant;
    logic        mem_rd_en;
    logic        mem_clr_en;
    logic [6:0]  mem_addr;
    logic [31:0] mem_rdata = '0;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic [1:0]  rd_tag;
    logic        window_tick;
    logic        clearing;
    logic        window_overrun;

    spike_readout_arbiter #(.N_REQ(4), .N_NEURON(128)) dut (
        .clk            (clk),
        .reset_bar      (reset_bar),
        .window_len     (window_len),
        .req            (req),
        .req_idx        (req_idx),
        .grant          (grant),
        .mem_rd_en      (mem_rd_en),
        .mem_clr_en     (mem_clr_en),
        .mem_addr       (mem_addr),
        .mem_rdata      (mem_rdata),
        .rd_valid       (rd_valid),
        .rd_data        (rd_data),
        .rd_tag         (rd_tag),
        .window_tick    (window_tick),
        .clearing       (clearing),
        .window_overrun (window_overrun)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model: everything is a cycle number counted from the reset-release cycle (cycle 0).
    typedef struct {
        int          due;
        logic [31:0] data;
        logic [1:0]  tag;
    } rd_t;
    rd_t         rdq[$];
    int          cyc;
    int          next_exp;
    int          clr_start;
    int          next_free;
    int          p;
    bit          pend;
    bit          ovr;
    int          m_gsel;
    logic [31:0] mem_arr[128];
    bit          prev_rd_en;
    logic [6:0]  prev_addr;

    int          obs_ticks, obs_clr, first_tick, first_clr, first_rdv;
    logic [31:0] last_rdata;
    logic [1:0]  last_rtag;
    logic [3:0]  glog[$];
    int          gtime[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic do_reset(input logic [31:0] wl);
        reset_bar = 1'b0;
        req = '0;
        #2;
        chk("rst_grant", 32'(grant), 0);
        chk("rst_rd_en", 32'(mem_rd_en), 0);
        chk("rst_clr_en", 32'(mem_clr_en), 0);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_rd_tag", 32'(rd_tag), 0);
        chk("rst_tick", 32'(window_tick), 0);
        chk("rst_clearing", 32'(clearing), 0);
        chk("rst_overrun", 32'(window_overrun), 0);
        repeat (2) @(posedge clk);
        #1;
        window_len = wl;
        reset_bar  = 1'b1;
        cyc        = 0;
        next_exp   = (wl == 0) ? -1 : int'(wl);
        clr_start  = -1;
        next_free  = 1;
        p          = 0;
        pend       = 1'b0;
        ovr        = 1'b0;
        m_gsel     = -1;
        rdq.delete();
        prev_rd_en = 1'b0;
        prev_addr  = '0;
        mem_rdata  = '0;
        obs_ticks  = 0;
        obs_clr    = 0;
        first_tick = -1;
        first_clr  = -1;
        first_rdv  = -1;
        last_rdata = '0;
        last_rtag  = '0;
        glog.delete();
        gtime.delete();
    endtask

    task automatic step();
        logic [3:0]  req_s;
        logic [27:0] idx_s;
        logic [31:0] wl_s;
        bit          pend_old, clr_old, e_clr, e_rd, e_tick, e_rdv, found;
        logic [3:0]  e_grant;
        logic [6:0]  e_addr;
        logic [31:0] e_rdata;
        logic [1:0]  e_rtag;
        int          sel;
        rd_t         r;
        req_s = req;
        idx_s = req_idx;
        wl_s  = window_len;
        @(posedge clk);
        #1;
        cyc++;
        m_gsel   = -1;
        pend_old = pend;
        clr_old  = (clr_start >= 0) && (cyc - 1 >= clr_start) && (cyc - 1 <= clr_start + 127);
        e_grant  = '0;
        e_rd     = 1'b0;
        e_tick   = 1'b0;
        e_addr   = '0;
        sel      = 0;
        found    = 1'b0;
        if (cyc >= next_free) begin
            if (pend_old) begin
                clr_start = cyc;
                next_free = cyc + 129;
                pend      = 1'b0;
                e_tick    = 1'b1;
            end else if (req_s != 4'b0000) begin
                for (int k = 0; k < 4; k++) begin
                    if (!found && req_s[(p + k) % 4]) begin
                        found = 1'b1;
                        sel   = (p + k) % 4;
                    end
                end
                e_grant    = 4'b0001 << sel;
                e_rd       = 1'b1;
                e_addr     = idx_s[sel*7 +: 7];
                r.due      = cyc + 2;
                r.data     = mem_arr[e_addr];
                r.tag      = 2'(sel);
                rdq.push_back(r);
                next_free  = cyc + 2;
                p          = (sel + 1) % 4;
                m_gsel     = sel;
            end
        end
        if (next_exp >= 0 && cyc == next_exp) begin
            if (pend_old || clr_old) ovr = 1'b1;
            else pend = 1'b1;
            next_exp = (wl_s == 0) ? -1 : cyc + int'(wl_s);
        end
        e_clr = (clr_start >= 0) && (cyc >= clr_start) && (cyc <= clr_start + 127);
        if (e_clr) e_addr = 7'(cyc - clr_start);
        e_rdv   = (rdq.size() > 0) && (rdq[0].due == cyc);
        e_rdata = '0;
        e_rtag  = '0;
        if (e_rdv) begin
            r       = rdq.pop_front();
            e_rdata = r.data;
            e_rtag  = r.tag;
        end

        chk("grant", 32'(grant), 32'(e_grant));
        chk("mem_rd_en", 32'(mem_rd_en), 32'(e_rd));
        chk("mem_clr_en", 32'(mem_clr_en), 32'(e_clr));
        chk("clearing", 32'(clearing), 32'(e_clr));
        chk("window_tick", 32'(window_tick), 32'(e_tick));
        chk("window_overrun", 32'(window_overrun), 32'(ovr));
        chk("rd_valid", 32'(rd_valid), 32'(e_rdv));
        if (e_rd || e_clr) chk("mem_addr", 32'(mem_addr), 32'(e_addr));
        if (e_rdv) begin
            chk("rd_data", rd_data, e_rdata);
            chk("rd_tag", 32'(rd_tag), 32'(e_rtag));
        end

        if (window_tick) begin
            obs_ticks++;
            if (first_tick < 0) first_tick = cyc;
        end
        if (mem_clr_en) begin
            obs_clr++;
            if (first_clr < 0) first_clr = cyc;
        end
        if (rd_valid) begin
            last_rdata = rd_data;
            last_rtag  = rd_tag;
            if (first_rdv < 0) first_rdv = cyc;
        end
        if (grant != 4'b0000) begin
            glog.push_back(grant);
            gtime.push_back(cyc);
        end

        // Count memory: data for the address read last cycle, junk otherwise.
        mem_rdata  = prev_rd_en ? mem_arr[prev_addr] : $urandom();
        prev_rd_en = mem_rd_en;
        prev_addr  = mem_addr;
    endtask

    task automatic drive_random();
        for (int i = 0; i < 4; i++) begin
            if (m_gsel == i) begin
                req[i] = 1'b0;
            end else if (!req[i]) begin
                req_idx[i*7 +: 7] = 7'($urandom_range(0, 127));
                if ($urandom_range(0, 3) == 0) req[i] = 1'b1;
            end else begin
                if ($urandom_range(0, 7) == 0) req_idx[i*7 +: 7] = 7'($urandom_range(0, 127));
                if ($urandom_range(0, 49) == 0) req[i] = 1'b0;
            end
        end
    endtask

    initial begin
        logic [3:0] exp_ord[5];
        exp_ord = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int i = 0; i < 128; i++) mem_arr[i] = $urandom();
        mem_arr[5] = 32'd42;

        // Single read with windowing disabled.
        do_reset(0);
        req_idx[6:0] = 7'd5;
        req = 4'b0001;
        step();
        repeat (5) begin
            if (m_gsel == 0) req[0] = 1'b0;
            step();
        end
        chk("A_ngrant", glog.size(), 1);
        if (gtime.size() > 0) chk("A_gnt_cyc", gtime[0], 1);
        chk("A_rdv_cyc", first_rdv, 3);
        chk("A_rd_data", last_rdata, 42);
        chk("A_rd_tag", 32'(last_rtag), 0);

        // All four requesting continuously.
        do_reset(0);
        req_idx = 28'($urandom());
        req = 4'b1111;
        repeat (12) step();
        chk("B_ngrant", glog.size(), 6);
        for (int k = 0; k < 5 && k + 1 < glog.size(); k++) begin
            chk("B_order", 32'(glog[k]), 32'(exp_ord[k]));
            chk("B_spacing", gtime[k+1] - gtime[k], 2);
        end

        // Periodic clears, no overrun.
        do_reset(200);
        repeat (540) step();
        chk("C_ticks", obs_ticks, 2);
        chk("C_clr_cycles", obs_clr, 256);
        chk("C_first_tick", first_tick, 201);
        chk("C_overrun", 32'(window_overrun), 0);

        // Window shorter than a sweep: sticky overrun.
        do_reset(100);
        repeat (350) step();
        chk("D_overrun", 32'(window_overrun), 1);

        // Expiry coincident with a grant; a later request waits for the sweep.
        do_reset(60);
        repeat (59) step();
        req_idx[13:7] = 7'd9;
        req = 4'b0010;
        step();
        req[1] = 1'b0;
        req_idx[20:14] = 7'd17;
        req[2] = 1'b1;
        repeat (200) begin
            if (m_gsel == 2) req[2] = 1'b0;
            step();
        end
        chk("E_rdv_cyc", first_rdv, 62);
        chk("E_rd_data", last_rdata, mem_arr[17]);
        chk("E_first_tick", first_tick, 62);
        chk("E_ngrant", glog.size(), 2);
        if (glog.size() > 1) begin
            chk("E_second_grant", 32'(glog[1]), 32'(4'b0100));
            chk("E_second_cyc", gtime[1], 191);
        end

        // Reset in the middle of a clear sweep.
        do_reset(30);
        repeat (91) step();
        chk("F_addr_before_rst", 32'(mem_addr), 60);
        do_reset(30);
        repeat (40) step();
        chk("F_first_clr", first_clr, 31);

        // Randomized traffic with window length changes mid-window.
        do_reset(32'($urandom_range(40, 300)));
        repeat (6) begin
            repeat (500) begin
                drive_random();
                step();
            end
            window_len = 32'($urandom_range(40, 300));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/spike_readout_arbiter.md
SPIKE_READOUT_ARBITER -- requirements
Module: spike_readout_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of readout requesters (fixed at 4 in this revision).
REQ-002 SHALL have parameter N_NEURON, default 128, number of count entries (7-bit address).
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port reset_bar  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port window_len  input  32  counting-window length in clk cycles; 0 disables windowing.
REQ-006 SHALL have port req  input  4  per-requester read request, level, held until granted.
REQ-007 SHALL have port req_idx  input  28  packed 7-bit neuron index per requester; requester i uses bits [7i+6:7i].
REQ-008 SHALL have port grant  output  4  one-hot, one-cycle grant pulse.
REQ-009 SHALL have port mem_rd_en  output  1  count-memory read strobe.
REQ-010 SHALL have port mem_clr_en  output  1  count-memory clear strobe for the entry at mem_addr.
REQ-011 SHALL have port mem_addr  output  7  count-memory address.
REQ-012 SHALL have port mem_rdata  input  32  count-memory data, valid exactly 1 cycle after mem_rd_en.
REQ-013 SHALL have port rd_valid  output  1  one-cycle pulse qualifying rd_data and rd_tag.
REQ-014 SHALL have port rd_data  output  32  returned spike count.
REQ-015 SHALL have port rd_tag  output  2  index of the requester that owns rd_data.
REQ-016 SHALL have port window_tick  output  1  one-cycle pulse on the first cycle of each clear sweep.
REQ-017 SHALL have port clearing  output  1  high for every cycle of a clear sweep.
REQ-018 SHALL have port window_overrun  output  1  sticky flag; set when a window expires while a clear is already pending or in progress.

Function
REQ-019 SHALL implement the states IDLE, READ and CLEAR, and all outputs SHALL be registered.
REQ-020 In IDLE with clear_pending set, the block SHALL enter CLEAR with mem_addr=0; a pending clear SHALL take priority over requests.
REQ-021 In IDLE with no clear pending and req!=0, the block SHALL select one requester round-robin, pulse its grant bit, assert mem_rd_en, drive mem_addr=req_idx[i] in the same cycle T, and go to READ.
REQ-022 Round-robin SHALL scan from pointer p upward modulo 4; after a grant to i, p SHALL become (i+1) mod 4; p SHALL reset to 0.
REQ-023 READ SHALL last 1 cycle (T+1) and capture mem_rdata; rd_valid, rd_data and rd_tag SHALL present that value at T+2, when the state is back in IDLE.
REQ-024 Throughput SHALL be at most 1 grant per 2 cycles; no new grant SHALL be issued in READ.
REQ-025 CLEAR SHALL assert mem_clr_en for 128 consecutive cycles with mem_addr=0..127 and then return to IDLE; no grants SHALL be issued during CLEAR.
REQ-026 The window counter SHALL count 0..window_len-1 and wrap, running continuously in all states; on the wrap cycle it SHALL set clear_pending.
REQ-027 window_len SHALL be sampled at each wrap; a change mid-window SHALL take effect on the next window, and window_len=0 SHALL hold the counter at 0 with no expiries.
REQ-028 An expiry during READ SHALL let the read complete; CLEAR SHALL follow on the next IDLE cycle.
REQ-029 An expiry while clear_pending=1 or clearing=1 SHALL set window_overrun (cleared only by reset); the extra expiry SHALL be dropped, not queued.
REQ-030 clear_pending SHALL clear on entry to CLEAR, and window_tick SHALL pulse in that same cycle.
REQ-031 Requests deasserted before grant SHALL be ignored; the req_idx bits of a requester SHALL be sampled only in its grant cycle.

Reset
REQ-032 While reset_bar=0: state=IDLE, grant=0, mem_rd_en=0, mem_clr_en=0, mem_addr=0, rd_valid=0, rd_data=0, rd_tag=0, window_tick=0, clearing=0, window_overrun=0, clear_pending=0, window counter=0, p=0.
REQ-033 Reset asserted mid-READ or mid-CLEAR SHALL abort immediately with no rd_valid pulse and no further clear strobes; after release the block SHALL begin in IDLE.

Verification
REQ-034 window_len=0, req=4'b0001, req_idx[6:0]=5, mem_rdata=42 -> grant=0001 at T, mem_addr=5, rd_valid at T+2 with rd_data=42 and rd_tag=0.
REQ-035 req=4'b1111 held continuously -> grants in order 0001, 0010, 0100, 1000, 0001 at 2-cycle spacing.
REQ-036 window_len=200, no req -> window_tick every 200 cycles, clearing high 128 cycles, mem_addr sweeps 0..127, window_overrun=0.
REQ-037 window_len=100 -> second expiry falls during clear -> window_overrun=1 and stays 1 until reset.
REQ-038 Expiry in the same cycle as a grant -> read completes (rd_valid at T+2), then window_tick and CLEAR start; a request pending at that point is granted only after CLEAR ends.
REQ-039 reset_bar pulsed low at clear address 60 -> all outputs return to reset values in the reset cycle; after release there is no mem_clr_en until the next expiry.
